// File: rtl/async_receiver_parity.sv
// async_receiver_parity
// RS-232 receiver for 8 data bits, even-XOR parity and one stop bit.
// The line is resynchronised, majority filtered at 16x the bit rate and
// sampled near each bit centre. Each completed frame produces a one-clk
// strobe along with the data byte, a parity error flag and a framing
// error flag, all three held until the next frame.

module async_receiver_parity #(
    parameter int ClkFrequency          = 50000000,
    parameter int Baud                  = 4800,
    parameter int Oversampling          = 16,
    parameter int BaudGeneratorAccWidth = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_parity_error,
    output logic       RxD_frame_error,
    output logic       RxD_idle
);

    localparam int unsigned CntWidth = $clog2(Oversampling);

    // Tick count at which the start bit is re-checked (half a bit in).
    localparam logic [CntWidth-1:0] StartCheck = CntWidth'(Oversampling / 2 - 1);
    // Tick count at which data, parity and stop bits are sampled (one bit on).
    localparam logic [CntWidth-1:0] BitSample  = CntWidth'(Oversampling - 1);

    // Ten bit times of high line before the receiver reports idle.
    localparam int unsigned IdleTicks = 10 * Oversampling;
    localparam logic [7:0]  IdleLimit = 8'(IdleTicks);

    // Fractional baud increment, rounded, evaluated at elaboration.
    localparam logic [63:0] IncWide =
        (((64'(Baud) * 64'd16) << (BaudGeneratorAccWidth - 7)) + (64'(ClkFrequency) >> 8))
        / (64'(ClkFrequency) >> 7);
    localparam logic [BaudGeneratorAccWidth:0] Inc = IncWide[BaudGeneratorAccWidth:0];

    typedef enum logic [3:0] {
        IDLE,
        START,
        BIT0,
        BIT1,
        BIT2,
        BIT3,
        BIT4,
        BIT5,
        BIT6,
        BIT7,
        PARITY,
        STOP,
        WAITHI
    } rxStateT;

    rxStateT state;
    rxStateT stateNext;

    logic [BaudGeneratorAccWidth:0] baudAcc;
    logic                           tick;

    logic [1:0]          rxSync;
    logic [2:0]          rxHist;
    logic                rxBit;

    logic [CntWidth-1:0] cnt;
    logic [7:0]          dataShift;
    logic                parityBit;
    logic [7:0]          idleCnt;

    logic                cntClear;
    logic                shiftData;
    logic                captureParity;
    logic                frameDone;

    // Free-running fractional accumulator; its carry is the oversampling tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baudAcc <= '0;
        end else begin
            baudAcc <= {1'b0, baudAcc[BaudGeneratorAccWidth-1:0]} + Inc;
        end
    end

    assign tick = baudAcc[BaudGeneratorAccWidth];

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxSync <= '1;
        end else begin
            rxSync <= {rxSync[0], RxD};
        end
    end

    // Three-sample history taken on each tick, feeding the majority filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxHist <= '1;
        end else if (tick) begin
            rxHist <= {rxHist[1:0], rxSync[1]};
        end
    end

    assign rxBit = (rxHist[0] & rxHist[1]) | (rxHist[0] & rxHist[2]) | (rxHist[1] & rxHist[2]);

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode plus the per-tick datapath controls.
    always_comb begin
        stateNext     = state;
        cntClear      = 1'b0;
        shiftData     = 1'b0;
        captureParity = 1'b0;
        frameDone     = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxBit) begin
                        stateNext = START;
                        cntClear  = 1'b1;
                    end
                end
                START: begin
                    if (cnt == StartCheck) begin
                        if (!rxBit) begin
                            stateNext = BIT0;
                            cntClear  = 1'b1;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
                BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6: begin
                    if (cnt == BitSample) begin
                        shiftData = 1'b1;
                        stateNext = rxStateT'(state + 4'd1);
                    end
                end
                BIT7: begin
                    if (cnt == BitSample) begin
                        shiftData = 1'b1;
                        stateNext = PARITY;
                    end
                end
                PARITY: begin
                    if (cnt == BitSample) begin
                        captureParity = 1'b1;
                        stateNext     = STOP;
                    end
                end
                STOP: begin
                    if (cnt == BitSample) begin
                        frameDone = 1'b1;
                        stateNext = rxBit ? IDLE : WAITHI;
                    end
                end
                WAITHI: begin
                    if (rxBit) begin
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // Oversampling phase counter; realigned to the start edge and the start centre.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cntClear ? '0 : cnt + CntWidth'(1);
        end
    end

    // Data bits arrive LSB first, so shift in from the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataShift <= '0;
            parityBit <= 1'b0;
        end else begin
            if (shiftData) begin
                dataShift <= {rxBit, dataShift[7:1]};
            end
            if (captureParity) begin
                parityBit <= rxBit;
            end
        end
    end

    // User-facing byte, flags and strobe, updated only when the stop bit is sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RxD_data         <= '0;
            RxD_data_ready   <= 1'b0;
            RxD_parity_error <= 1'b0;
            RxD_frame_error  <= 1'b0;
        end else begin
            RxD_data_ready <= frameDone;
            if (frameDone) begin
                RxD_data         <= dataShift;
                RxD_frame_error  <= !rxBit;
                RxD_parity_error <= parityBit ^ (^dataShift);
            end
        end
    end

    // Saturating count of high ticks spent in IDLE; any other condition clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idleCnt <= '0;
        end else if ((state == IDLE) && rxBit) begin
            if (tick && (idleCnt != IdleLimit)) begin
                idleCnt <= idleCnt + 8'd1;
            end
        end else begin
            idleCnt <= '0;
        end
    end

    assign RxD_idle = (idleCnt == IdleLimit) && (state == IDLE);

endmodule
